// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with ready/valid handshake and a 2-entry skid buffer.
// in_ready comes only from registered state, so MEM back-pressure never reaches EX combinationally.
module ex_mem_skid_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_write_data,
  input  logic [RADDR_W-1:0] in_write_reg_addr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic [DATA_W-1:0]  out_write_data,
  output logic [RADDR_W-1:0] out_write_reg_addr,
  output logic [1:0]         occupancy
);

  logic               r_main_valid;
  logic               r_skid_valid;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [DATA_W-1:0]  r_main_alu;
  logic [DATA_W-1:0]  r_main_wdata;
  logic [RADDR_W-1:0] r_main_waddr;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [DATA_W-1:0]  r_skid_alu;
  logic [DATA_W-1:0]  r_skid_wdata;
  logic [RADDR_W-1:0] r_skid_waddr;

  logic w_accept;
  logic w_consume;
  logic w_load_main_in;
  logic w_load_skid;
  logic w_promote;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;

  assign in_ready  = ~r_skid_valid & ~reset;
  assign out_valid = r_main_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_main_valid & out_ready;

  // Occupancy control: skid is only ever valid while main is valid.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_skid      = 1'b0;
    w_promote        = 1'b0;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (r_skid_valid) begin
      if (w_consume) begin
        w_promote        = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (r_main_valid) begin
      if (w_accept && w_consume) begin
        w_load_main_in = 1'b1;
      end else if (w_accept) begin
        w_load_skid      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end else if (w_consume) begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_load_main_in   = 1'b1;
      w_main_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // Head slot: loads from EX directly or from the skid slot as it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_ctrl  <= '0;
      r_main_alu   <= '0;
      r_main_wdata <= '0;
      r_main_waddr <= '0;
    end else if (w_load_main_in) begin
      r_main_ctrl  <= in_ctrl;
      r_main_alu   <= in_alu_result;
      r_main_wdata <= in_write_data;
      r_main_waddr <= in_write_reg_addr;
    end else if (w_promote) begin
      r_main_ctrl  <= r_skid_ctrl;
      r_main_alu   <= r_skid_alu;
      r_main_wdata <= r_skid_wdata;
      r_main_waddr <= r_skid_waddr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_ctrl  <= '0;
      r_skid_alu   <= '0;
      r_skid_wdata <= '0;
      r_skid_waddr <= '0;
    end else if (w_load_skid) begin
      r_skid_ctrl  <= in_ctrl;
      r_skid_alu   <= in_alu_result;
      r_skid_wdata <= in_write_data;
      r_skid_waddr <= in_write_reg_addr;
    end
  end

  // Bubbles never carry mem_write/reg_write; data fields simply hold.
  assign out_ctrl           = r_main_ctrl & {CTRL_W{r_main_valid}};
  assign out_alu_result     = r_main_alu;
  assign out_write_data     = r_main_wdata;
  assign out_write_reg_addr = r_main_waddr;
  assign occupancy          = {r_skid_valid, r_main_valid & ~r_skid_valid};

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed scenarios plus random traffic
// compared against a FIFO-of-depth-2 queue model.
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [3:0]  in_ctrl, out_ctrl;
  logic [31:0] in_alu_result, in_write_data, out_alu_result, out_write_data;
  logic [4:0]  in_write_reg_addr, out_write_reg_addr;
  logic [1:0]  occupancy;

  logic        wd_in_valid, wd_in_ready, wd_flush, wd_out_valid, wd_out_ready;
  logic [5:0]  wd_in_ctrl, wd_out_ctrl, wd_in_wra, wd_out_wra;
  logic [63:0] wd_in_alu, wd_in_wd, wd_out_alu, wd_out_wd;
  logic [1:0]  wd_occ;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wra;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .in_write_reg_addr(in_write_reg_addr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu_result(out_alu_result),
    .out_write_data(out_write_data), .out_write_reg_addr(out_write_reg_addr),
    .occupancy(occupancy)
  );

  ex_mem_skid_stage #(.DATA_W(64), .RADDR_W(6), .CTRL_W(6)) dut_wide (
    .clk(clk), .reset(reset), .in_valid(wd_in_valid), .in_ready(wd_in_ready),
    .in_ctrl(wd_in_ctrl), .in_alu_result(wd_in_alu), .in_write_data(wd_in_wd),
    .in_write_reg_addr(wd_in_wra), .flush(wd_flush), .out_valid(wd_out_valid),
    .out_ready(wd_out_ready), .out_ctrl(wd_out_ctrl), .out_alu_result(wd_out_alu),
    .out_write_data(wd_out_wd), .out_write_reg_addr(wd_out_wra), .occupancy(wd_occ)
  );

  // Reference: a queue holding at most two entries; flush/reset empty it.
  task automatic tick();
    bit acc, cons;
    ent_t e;
    acc  = in_valid && (q.size() < 2) && !reset;
    cons = out_ready && (q.size() > 0);
    e.ctrl = in_ctrl; e.alu = in_alu_result; e.wd = in_write_data; e.wra = in_write_reg_addr;
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a);
    in_valid = v; in_ctrl = c; in_alu_result = a;
    in_write_data = ~a; in_write_reg_addr = a[4:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b1, 4'hF, 32'h55);
    wd_in_valid = 1'b0; wd_flush = 1'b0; wd_out_ready = 1'b0;
    wd_in_ctrl = '0; wd_in_alu = '0; wd_in_wd = '0; wd_in_wra = '0;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_ctrl !== 4'h0) begin n_errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
    n_checks++; if (occupancy !== 2'd0) begin n_errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++; if (out_alu_result !== 32'h0) begin n_errors++; $display("FAIL reset_alu got %h exp 0", out_alu_result); end
    reset = 1'b0; drive(1'b0, 4'h0, 32'h0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'h4, 32'(i));
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'(i)) begin
        n_errors++; $display("FAIL stream_head[%0d] got v=%b alu=%0d exp v=1 alu=%0d", i, out_valid, out_alu_result, i); end
      n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        n_errors++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%b exp occ=1 rdy=1", i, occupancy, in_ready); end
    end
    drive(1'b0, 4'h0, 32'h0);
    tick();
    n_checks++; if (occupancy !== 2'd0 || out_ctrl !== 4'h0) begin
      n_errors++; $display("FAIL stream_drain got occ=%0d ctrl=%h exp occ=0 ctrl=0", occupancy, out_ctrl); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 32'hA); tick();
    drive(1'b1, 4'h2, 32'hB); tick();
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      n_errors++; $display("FAIL skid_full got occ=%0d rdy=%b alu=%h exp occ=2 rdy=0 alu=a", occupancy, in_ready, out_alu_result); end
    drive(1'b1, 4'h3, 32'hC); tick();
    n_checks++; if (occupancy !== 2'd2 || out_alu_result !== 32'hA || out_ctrl !== 4'h1) begin
      n_errors++; $display("FAIL skid_hold got occ=%0d alu=%h ctrl=%h exp occ=2 alu=a ctrl=1", occupancy, out_alu_result, out_ctrl); end
    out_ready = 1'b1; tick();
    n_checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'hB || out_write_data !== ~32'hB || occupancy !== 2'd1) begin
      n_errors++; $display("FAIL skid_drain_b got v=%b alu=%h occ=%0d exp v=1 alu=b occ=1", out_valid, out_alu_result, occupancy); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'hC || out_ctrl !== 4'h3) begin
      n_errors++; $display("FAIL skid_drain_c got v=%b alu=%h ctrl=%h exp v=1 alu=c ctrl=3", out_valid, out_alu_result, out_ctrl); end
    drive(1'b0, 4'h0, 32'h0); tick();
    n_checks++; if (out_valid !== 1'b0 || out_alu_result !== 32'hC) begin
      n_errors++; $display("FAIL skid_empty got v=%b alu=%h exp v=0 alu=c (held)", out_valid, out_alu_result); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, 32'hA0); tick();
    drive(1'b1, 4'b1111, 32'hB0); tick();
    n_checks++; if (out_ctrl !== 4'b0110 || occupancy !== 2'd2) begin
      n_errors++; $display("FAIL flush_pre got ctrl=%b occ=%0d exp ctrl=0110 occ=2", out_ctrl, occupancy); end
    flush = 1'b1; drive(1'b1, 4'hF, 32'hF0); tick();
    flush = 1'b0; drive(1'b0, 4'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0) begin
      n_errors++; $display("FAIL flush_full got v=%b ctrl=%h occ=%0d exp 0/0/0", out_valid, out_ctrl, occupancy); end
    // Flush while ONE with a simultaneous accept: the accepted entry is lost too.
    drive(1'b1, 4'h4, 32'hC0); tick();
    flush = 1'b1; out_ready = 1'b1; drive(1'b1, 4'h4, 32'hF1); tick();
    flush = 1'b0; drive(1'b0, 4'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_errors++; $display("FAIL flush_one got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_errors++; $display("FAIL flush_discard got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_random();
    ent_t hd;
    for (int c = 0; c < 10000; c++) begin
      hd = {out_ctrl, out_alu_result, out_write_data, out_write_reg_addr};
      n_checks++;
      if (q.size() == 0) begin
        if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
          n_errors++; $display("FAIL rand_empty[%0d] got v=%b ctrl=%h occ=%0d rdy=%b exp 0/0/0/1",
                               c, out_valid, out_ctrl, occupancy, in_ready); end
      end else if (out_valid !== 1'b1 || hd !== q[0] || occupancy !== 2'(q.size()) ||
                   in_ready !== (q.size() < 2)) begin
        n_errors++; $display("FAIL rand_head[%0d] got v=%b ent=%h occ=%0d rdy=%b exp v=1 ent=%h occ=%0d",
                             c, out_valid, hd, occupancy, in_ready, q[0], q.size());
      end
      in_valid = 1'($urandom_range(0, 1));
      in_ctrl = 4'($urandom); in_alu_result = $urandom; in_write_data = $urandom;
      in_write_reg_addr = 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; drive(1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, 32'h1A); tick();
    drive(1'b1, 4'b0110, 32'h1B); tick();
    n_checks++; if (occupancy !== 2'd2) begin n_errors++; $display("FAIL areset_pre got occ=%0d exp 2", occupancy); end
    #2 reset = 1'b1;
    #1;
    q.delete();
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL areset_mid got v=%b ctrl=%h occ=%0d rdy=%b exp 0/0/0/0", out_valid, out_ctrl, occupancy, in_ready); end
    @(negedge clk);
    reset = 1'b0; drive(1'b1, 4'h8, 32'h77); tick();
    drive(1'b0, 4'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h77 || out_ctrl !== 4'h8) begin
      n_errors++; $display("FAIL areset_first got v=%b alu=%h ctrl=%h exp v=1 alu=77 ctrl=8", out_valid, out_alu_result, out_ctrl); end
  endtask

  task automatic test_wide();
    wd_out_ready = 1'b0; wd_in_valid = 1'b1; wd_in_ctrl = 6'h3F;
    wd_in_alu = 64'hDEAD_BEEF_0123_4567; wd_in_wd = 64'hFEDC_BA98_7654_3210; wd_in_wra = 6'h2A;
    tick();
    wd_in_valid = 1'b0; wd_in_alu = '0; wd_in_ctrl = '0;
    n_checks++; if (wd_out_valid !== 1'b1 || wd_out_ctrl !== 6'h3F || wd_out_alu !== 64'hDEAD_BEEF_0123_4567) begin
      n_errors++; $display("FAIL wide_head got v=%b ctrl=%h alu=%h exp v=1 ctrl=3f alu=deadbeef01234567", wd_out_valid, wd_out_ctrl, wd_out_alu); end
    n_checks++; if (wd_out_wd !== 64'hFEDC_BA98_7654_3210 || wd_out_wra !== 6'h2A || wd_occ !== 2'd1) begin
      n_errors++; $display("FAIL wide_fields got wd=%h wra=%h occ=%0d exp wd=fedcba9876543210 wra=2a occ=1", wd_out_wd, wd_out_wra, wd_occ); end
    wd_out_ready = 1'b1; tick();
    n_checks++; if (wd_out_valid !== 1'b0 || wd_out_ctrl !== 6'h0 || wd_out_alu !== 64'hDEAD_BEEF_0123_4567) begin
      n_errors++; $display("FAIL wide_bubble got v=%b ctrl=%h alu=%h exp v=0 ctrl=0 alu held", wd_out_valid, wd_out_ctrl, wd_out_alu); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised EX→MEM pipeline stage register with a ready/valid handshake and a 2-entry skid buffer.
- Carries the M-stage and WB-stage control fields, ALU result, store data and destination register address.
- Supports back-pressure from MEM without a combinational ready path, plus synchronous flush.
- Replaces the free-running stage register wherever MEM can stall (multi-cycle data memory).

Parameters:
DATA_W, 32, width of alu_result and write_data
RADDR_W, 5, width of destination register address
CTRL_W, 4, width of packed control bus; bit0 mem_read, bit1 mem_write, bit2 reg_write, bit3 mem_to_reg, upper bits user-defined

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  packed control fields from EX
in_alu_result  input  DATA_W  ALU result / memory address
in_write_data  input  DATA_W  store data
in_write_reg_addr  input  RADDR_W  destination register
flush  input  1  synchronous kill of all held entries
out_valid  output  1  head entry valid toward MEM
out_ready  input  1  MEM consumes head this cycle
out_ctrl  output  CTRL_W  head control fields, forced to 0 when out_valid=0
out_alu_result  output  DATA_W  head ALU result
out_write_data  output  DATA_W  head store data
out_write_reg_addr  output  RADDR_W  head destination register
occupancy  output  2  number of held entries (0..2)

Behaviour:
- Storage: main slot (drives out_*) and skid slot; each with its own valid bit. All out_* and in_ready are driven from registers or from a single AND with out_valid; there is no combinational path from out_ready to in_ready.
- in_ready = ~skid_valid & ~reset. It is registered-derived and equals 1 when occupancy < 2.
- Accept event: in_valid & in_ready. Consume event: out_valid & out_ready.
- States (occupancy):
  - EMPTY(0):
    - accept → ONE; input is loaded into main.
  - ONE(1):
    - accept & consume → ONE; main loads input.
    - accept only → FULL; input goes to skid.
    - consume only → EMPTY.
    - neither → hold.
  - FULL(2): in_ready=0, so no accept.
    - consume → ONE; skid moves to main, skid cleared.
    - no consume → hold.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush.
- Latency: an accepted entry appears on out_* on the next rising edge when the stage was EMPTY, or when it was ONE with a consume in the same cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Flush:
  - Next edge clears both valid bits; occupancy becomes 0.
  - Any entry accepted in the flush cycle is discarded.
  - Flush has priority over accept and consume. A consume in the flush cycle still counts on the MEM side.
- Gating: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. mem_write and reg_write are therefore never asserted for a bubble. Data fields are held (not zeroed) when invalid.
- Reset:
  - Valid bits cleared; all data/ctrl registers cleared to 0.
  - out_valid=0, out_ctrl=0, occupancy=0.
  - in_ready=0 while reset is high, 1 on the first cycle after release.
  - Reset mid-operation discards all entries immediately (asynchronous).
- Data registers load only on their load events. Idle slots do not toggle.
- X-safety: in_* are don't-care when in_valid=0 and must not affect state.

Test Plan:
- Reset release, then in_valid=1 every cycle with alu_result=1,2,3…, out_ready=1 → out_valid from cycle 2; out_alu_result 1,2,3 one per cycle; occupancy stays 1; in_ready stays 1.
- Stream entries A,B,C with out_ready=0 → A at head, B in skid, occupancy=2, in_ready=0, C held by EX. Then out_ready=1 → outputs A,B,C in order with no gap.
- FULL with ctrl=4'b0110 at head; assert flush for one cycle with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, and the flushed-cycle input never appears.
- Random in_valid/out_ready (50%) for 10k cycles, compared against a reference queue → no loss, duplication or reordering; out_ctrl==0 whenever out_valid==0.
- Assert reset asynchronously mid-clock while FULL → out_valid, out_ctrl and occupancy go to 0 before the next edge; first post-reset accept appears 1 cycle later.
- Non-default parameters DATA_W=64, RADDR_W=6, CTRL_W=6, with an accepted value of 64'hDEAD_BEEF_0123_4567 and all-ones ctrl → full-width values pass intact.
